// File: rtl/aim_dispatch_queue.sv
// Dispatch stage behind the AIM decoder: steers each decoded instruction into an
// AI or graphics FIFO, drops and counts instructions that belong to neither class.
module aim_dispatch_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16,
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_ai,
    input  logic             in_is_gfx,
    input  logic [5:0]       in_opcode,
    input  logic [3:0]       in_type,
    input  logic [7:0]       in_src,
    input  logic [7:0]       in_dst,
    input  logic [7:0]       in_imm,
    output logic             ai_valid,
    input  logic             ai_ready,
    output logic [33:0]      ai_payload,
    output logic             gfx_valid,
    input  logic             gfx_ready,
    output logic [33:0]      gfx_payload,
    output logic [LVL_W-1:0] ai_level,
    output logic [LVL_W-1:0] gfx_level,
    output logic             illegal_pulse,
    output logic [CNT_W-1:0] ai_count,
    output logic [CNT_W-1:0] gfx_count,
    output logic [CNT_W-1:0] illegal_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int PAY_W = 34;

    // Index 0 is the AI class, index 1 the graphics class.
    logic [1:0]       cls_sel;
    logic             is_illegal;
    logic             accept;
    logic [PAY_W-1:0] in_word;
    logic [1:0]       full;
    logic [1:0]       push;
    logic [1:0]       pop;
    logic [1:0]       out_ready;
    logic [1:0]       out_valid;
    logic [PAY_W-1:0] head [2];
    logic [LVL_W-1:0] level [2];
    logic [CNT_W-1:0] hand_cnt [2];

    logic             illegal_pulse_reg;
    logic [CNT_W-1:0] illegal_cnt_reg;

    assign cls_sel    = {in_is_gfx & ~in_is_ai, in_is_ai & ~in_is_gfx};
    assign is_illegal = ~(cls_sel[0] | cls_sel[1]);
    assign in_word    = {in_opcode, in_type, in_src, in_dst, in_imm};
    assign out_ready  = {gfx_ready, ai_ready};

    // Ready depends only on the class of the offered word, never on a pop this cycle.
    always_comb begin
        in_ready = 1'b0;
        if (!flush) begin
            if (cls_sel[0])
                in_ready = ~full[0];
            else if (cls_sel[1])
                in_ready = ~full[1];
            else
                in_ready = 1'b1;
        end
    end

    assign accept = in_valid & in_ready;
    assign push   = {2{accept}} & cls_sel;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [PAY_W-1:0] mem_reg [DEPTH];
        logic [PTR_W-1:0] wr_ptr_reg;
        logic [PTR_W-1:0] rd_ptr_reg;
        logic [LVL_W-1:0] level_reg;
        logic [CNT_W-1:0] cnt_reg;

        assign full[gi]      = (level_reg == LVL_W'(DEPTH));
        assign out_valid[gi] = (level_reg != '0) & ~flush;
        assign pop[gi]       = out_valid[gi] & out_ready[gi];
        assign head[gi]      = mem_reg[rd_ptr_reg];
        assign level[gi]     = level_reg;
        assign hand_cnt[gi]  = cnt_reg;

        always_ff @(posedge clk) begin
            if (push[gi])
                mem_reg[wr_ptr_reg] <= in_word;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                level_reg  <= '0;
                cnt_reg    <= '0;
            end else if (flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                level_reg  <= '0;
            end else begin
                if (push[gi])
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (pop[gi])
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                if (push[gi] && !pop[gi])
                    level_reg <= level_reg + LVL_W'(1);
                else if (!push[gi] && pop[gi])
                    level_reg <= level_reg - LVL_W'(1);
                if (pop[gi] && cnt_reg != '1)
                    cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // Flush forces in_ready low, so no illegal word is accepted in a flush cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_pulse_reg <= 1'b0;
            illegal_cnt_reg   <= '0;
        end else begin
            illegal_pulse_reg <= accept & is_illegal;
            if (accept && is_illegal && illegal_cnt_reg != '1)
                illegal_cnt_reg <= illegal_cnt_reg + CNT_W'(1);
        end
    end

    assign ai_valid      = out_valid[0];
    assign gfx_valid     = out_valid[1];
    assign ai_payload    = head[0];
    assign gfx_payload   = head[1];
    assign ai_level      = level[0];
    assign gfx_level     = level[1];
    assign ai_count      = hand_cnt[0];
    assign gfx_count     = hand_cnt[1];
    assign illegal_pulse = illegal_pulse_reg;
    assign illegal_count = illegal_cnt_reg;

endmodule

// File: tb/tb_aim_dispatch_queue.sv
// Bench for aim_dispatch_queue: scoreboard model checked every cycle, a vector table
// for the basic flows, hand sequences for full/flush/saturation/reset, then random traffic.
`timescale 1ns/1ps
module tb_aim_dispatch_queue;
    localparam int DEPTH = 4;
    localparam int LVL_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, flush, in_valid, in_ready, in_is_ai, in_is_gfx;
    logic [5:0] in_opcode;
    logic [3:0] in_type;
    logic [7:0] in_src, in_dst, in_imm;
    logic ai_valid, ai_ready, gfx_valid, gfx_ready, illegal_pulse;
    logic [33:0] ai_payload, gfx_payload;
    logic [LVL_W-1:0] ai_level, gfx_level;
    logic [15:0] ai_count, gfx_count, illegal_count;

    logic s_in_ready, s_ai_valid, s_gfx_valid, s_illegal_pulse;
    logic [33:0] s_ai_payload, s_gfx_payload;
    logic [LVL_W-1:0] s_ai_level, s_gfx_level;
    logic [1:0] s_ai_count, s_gfx_count, s_illegal_count;

    aim_dispatch_queue #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_is_ai(in_is_ai), .in_is_gfx(in_is_gfx), .in_opcode(in_opcode), .in_type(in_type),
        .in_src(in_src), .in_dst(in_dst), .in_imm(in_imm),
        .ai_valid(ai_valid), .ai_ready(ai_ready), .ai_payload(ai_payload),
        .gfx_valid(gfx_valid), .gfx_ready(gfx_ready), .gfx_payload(gfx_payload),
        .ai_level(ai_level), .gfx_level(gfx_level), .illegal_pulse(illegal_pulse),
        .ai_count(ai_count), .gfx_count(gfx_count), .illegal_count(illegal_count));

    aim_dispatch_queue #(.DEPTH(DEPTH), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_is_ai(in_is_ai), .in_is_gfx(in_is_gfx), .in_opcode(in_opcode), .in_type(in_type),
        .in_src(in_src), .in_dst(in_dst), .in_imm(in_imm),
        .ai_valid(s_ai_valid), .ai_ready(ai_ready), .ai_payload(s_ai_payload),
        .gfx_valid(s_gfx_valid), .gfx_ready(gfx_ready), .gfx_payload(s_gfx_payload),
        .ai_level(s_ai_level), .gfx_level(s_gfx_level), .illegal_pulse(s_illegal_pulse),
        .ai_count(s_ai_count), .gfx_count(s_gfx_count), .illegal_count(s_illegal_count));

    int checks = 0;
    int errors = 0;

    logic [33:0] ai_q[$];
    logic [33:0] gfx_q[$];
    int  m_ai_cnt, m_gfx_cnt, m_ill_cnt;
    bit  m_pulse;

    typedef struct {
        bit v, a, g, ar, gr;
        logic [33:0] w;
        bit exp_rdy;
        int exp_ai_lvl;
        int exp_gfx_lvl;
    } vec_t;
    vec_t vecs[14];

    function automatic int sat(int v, int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(bit v, bit a, bit g, logic [33:0] w, bit ar, bit gr, bit fl, bit rn);
        in_valid  = v;
        in_is_ai  = a;
        in_is_gfx = g;
        {in_opcode, in_type, in_src, in_dst, in_imm} = w;
        ai_ready  = ar;
        gfx_ready = gr;
        flush     = fl;
        rst_n     = rn;
    endtask

    // Compare DUT against the model, then advance model and DUT by one clock.
    task automatic step();
        bit is_a, is_g, exp_rdy, eav, egv, acc;
        logic [33:0] w;
        #1;
        is_a = in_is_ai && !in_is_gfx;
        is_g = in_is_gfx && !in_is_ai;
        exp_rdy = flush ? 1'b0 : is_a ? (ai_q.size() < DEPTH) : is_g ? (gfx_q.size() < DEPTH) : 1'b1;
        eav = (ai_q.size() > 0) && !flush;
        egv = (gfx_q.size() > 0) && !flush;
        chk("in_ready", in_ready, exp_rdy);
        chk("ai_valid", ai_valid, eav);
        chk("gfx_valid", gfx_valid, egv);
        chk("ai_level", ai_level, ai_q.size());
        chk("gfx_level", gfx_level, gfx_q.size());
        chk("illegal_pulse", illegal_pulse, m_pulse);
        chk("ai_count", ai_count, sat(m_ai_cnt, 16));
        chk("gfx_count", gfx_count, sat(m_gfx_cnt, 16));
        chk("illegal_count", illegal_count, sat(m_ill_cnt, 16));
        chk("sat_ai_count", s_ai_count, sat(m_ai_cnt, 2));
        chk("sat_gfx_count", s_gfx_count, sat(m_gfx_cnt, 2));
        chk("sat_illegal_count", s_illegal_count, sat(m_ill_cnt, 2));
        if (eav) chk("ai_payload", ai_payload, ai_q[0]);
        if (egv) chk("gfx_payload", gfx_payload, gfx_q[0]);
        acc = in_valid && exp_rdy;
        w = {in_opcode, in_type, in_src, in_dst, in_imm};
        @(posedge clk);
        if (!rst_n) begin
            ai_q.delete();
            gfx_q.delete();
            m_ai_cnt = 0; m_gfx_cnt = 0; m_ill_cnt = 0;
            m_pulse = 1'b0;
        end else if (flush) begin
            ai_q.delete();
            gfx_q.delete();
            m_pulse = 1'b0;
        end else begin
            if (eav && ai_ready) begin void'(ai_q.pop_front()); m_ai_cnt++; end
            if (egv && gfx_ready) begin void'(gfx_q.pop_front()); m_gfx_cnt++; end
            if (acc && is_a) ai_q.push_back(w);
            if (acc && is_g) gfx_q.push_back(w);
            m_pulse = acc && !is_a && !is_g;
            if (m_pulse) m_ill_cnt++;
        end
        @(negedge clk);
    endtask

    localparam logic [33:0] W1 = {6'h05, 4'h3, 8'h11, 8'h22, 8'h33};
    localparam logic [33:0] W2 = {6'h0A, 4'h1, 8'h01, 8'h02, 8'h03};
    localparam logic [33:0] W3 = {6'h15, 4'h2, 8'h04, 8'h05, 8'h06};
    localparam logic [33:0] W4 = {6'h2A, 4'h4, 8'h07, 8'h08, 8'h09};
    localparam logic [33:0] W5 = {6'h3F, 4'hF, 8'hAA, 8'hBB, 8'hCC};
    localparam logic [33:0] G1 = {6'h21, 4'h7, 8'h31, 8'h32, 8'h33};
    localparam logic [33:0] X1 = {6'h33, 4'h0, 8'hDE, 8'hAD, 8'hBE};

    initial begin
        logic [15:0] saved_cnt;
        logic [33:0] rw;
        m_ai_cnt = 0; m_gfx_cnt = 0; m_ill_cnt = 0; m_pulse = 1'b0;

        vecs[0]  = '{1, 1, 0, 0, 0, W1, 1, 1, 0};
        vecs[1]  = '{1, 1, 0, 0, 0, W2, 1, 2, 0};
        vecs[2]  = '{1, 1, 0, 0, 0, W3, 1, 3, 0};
        vecs[3]  = '{1, 1, 0, 0, 0, W4, 1, 4, 0};
        vecs[4]  = '{1, 1, 0, 0, 0, W5, 0, 4, 0};
        vecs[5]  = '{1, 0, 1, 0, 0, G1, 1, 4, 1};
        vecs[6]  = '{0, 0, 0, 1, 0, X1, 1, 3, 1};
        vecs[7]  = '{0, 0, 0, 1, 0, X1, 1, 2, 1};
        vecs[8]  = '{0, 0, 0, 1, 0, X1, 1, 1, 1};
        vecs[9]  = '{0, 0, 0, 1, 0, X1, 1, 0, 1};
        vecs[10] = '{1, 0, 0, 0, 0, X1, 1, 0, 1};
        vecs[11] = '{0, 0, 0, 0, 0, X1, 1, 0, 1};
        vecs[12] = '{1, 1, 1, 0, 0, X1, 1, 0, 1};
        vecs[13] = '{0, 0, 0, 0, 0, X1, 1, 0, 1};

        drive(0, 0, 0, '0, 0, 0, 0, 0);
        @(negedge clk);
        step();
        drive(0, 0, 0, '0, 0, 0, 0, 1);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].v, vecs[i].a, vecs[i].g, vecs[i].w, vecs[i].ar, vecs[i].gr, 0, 1);
            #1 chk($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].exp_rdy);
            step();
            chk($sformatf("vec%0d_ai_level", i), ai_level, vecs[i].exp_ai_lvl);
            chk($sformatf("vec%0d_gfx_level", i), gfx_level, vecs[i].exp_gfx_lvl);
            if (i == 0) chk("first_ai_payload", ai_payload, 34'h0_5311_2233);
        end
        chk("drained_ai_count", ai_count, 16'd4);
        chk("illegal_count_two", illegal_count, 16'd2);

        // GFX full, pop and offer in the same cycle: refused, then accepted next cycle
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, G1 + 34'(i + 1), 0, 0, 0, 1);
            step();
        end
        chk("gfx_full_level", gfx_level, 3'd4);
        drive(1, 0, 1, W5, 0, 1, 0, 1);
        #1 chk("gfx_full_ready", in_ready, 1'b0);
        step();
        chk("gfx_pop_level", gfx_level, 3'd3);
        step();
        chk("gfx_steady_level", gfx_level, 3'd3);

        // Flush with both FIFOs occupied
        drive(1, 1, 0, W2, 0, 0, 0, 1); step();
        drive(1, 1, 0, W3, 0, 0, 0, 1); step();
        chk("preflush_ai_level", ai_level, 3'd2);
        chk("preflush_gfx_level", gfx_level, 3'd3);
        saved_cnt = ai_count;
        drive(1, 1, 0, W4, 1, 1, 1, 1);
        #1 chk("flush_ai_valid", ai_valid, 1'b0);
        chk("flush_in_ready", in_ready, 1'b0);
        step();
        chk("postflush_ai_level", ai_level, 3'd0);
        chk("postflush_gfx_level", gfx_level, 3'd0);
        chk("postflush_ai_count", ai_count, saved_cnt);

        // Saturation on the narrow-counter instance, then reset mid-stream
        drive(0, 0, 0, '0, 0, 0, 0, 0); step();
        for (int i = 0; i < 6; i++) begin
            drive(i < 5, 1, 0, W1 + 34'(i), 1, 0, 0, 1);
            step();
        end
        chk("wide_ai_count", ai_count, 16'd5);
        chk("sat_ai_count_hold", s_ai_count, 2'd3);
        drive(1, 1, 0, W2, 0, 0, 0, 1); step();
        drive(1, 0, 1, G1, 0, 0, 0, 1); step();
        drive(1, 1, 1, X1, 0, 0, 0, 1); step();
        drive(1, 1, 1, X1, 1, 1, 0, 0); step();
        chk("rst_ai_valid", ai_valid, 1'b0);
        chk("rst_gfx_valid", gfx_valid, 1'b0);
        chk("rst_ai_level", ai_level, 3'd0);
        chk("rst_illegal_pulse", illegal_pulse, 1'b0);
        chk("rst_ai_count", ai_count, 16'd0);
        chk("rst_illegal_count", illegal_count, 16'd0);

        for (int i = 0; i < 400; i++) begin
            rw = {$urandom, $urandom};
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 2) == 0, rw,
                  $urandom_range(0, 1), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 63) != 0);
            step();
        end
        drive(0, 0, 0, '0, 0, 0, 0, 1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
